// File: rtl/axi_stream_slave_blk.sv
// Packs AXI-Stream beats MSB-first into BLK_WIDTH blocks behind a single
// registered output stage; a packet ending mid-block is zero-padded and flagged.
//
// state   | meaning
// COLLECT | tready=1, beats written into the assembly buffer
// FULL    | tready=0, a completed block waits for the output register
module axi_stream_slave_blk #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BLK_WIDTH        = 128
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          tvalid,
    output logic                          tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]   tdata,
    input  logic [AXIS_TDATA_WIDTH/8-1:0] tstrb,
    input  logic                          tlast,
    output logic                          blk_tvalid,
    input  logic                          blk_tready,
    output logic [BLK_WIDTH-1:0]          blk_tdata,
    output logic                          blk_tlast,
    output logic                          err_partial
);

    localparam int N     = BLK_WIDTH / AXIS_TDATA_WIDTH;
    localparam int W     = AXIS_TDATA_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [W-1:0]           asm_q [N];
    logic [CNT_W-1:0]       count_q;
    logic                   pend_last_q;
    logic                   tready_q;
    logic                   blk_tvalid_q;
    logic                   blk_tlast_q;
    logic [BLK_WIDTH-1:0]   blk_tdata_q;
    logic                   err_partial_q;

    logic                   beat_acc;
    logic                   out_free;
    logic                   is_final;
    logic                   store_beat;
    logic                   load_beat;
    logic                   load_buf;
    logic [BLK_WIDTH-1:0]   beat_block;
    logic [BLK_WIDTH-1:0]   buf_block;

    // Byte strobes carry no meaning here; every byte is taken as valid.
    logic unused_tstrb;
    assign unused_tstrb = ^tstrb;

    assign beat_acc = tvalid && tready_q;
    assign out_free = !blk_tvalid_q || blk_tready;
    assign is_final = (count_q == LAST_IDX) || tlast;

    // beat_block is the buffer with the incoming beat merged at index count,
    // so a final beat can go straight to the output register.
    always_comb begin
        beat_block = '0;
        buf_block  = '0;
        for (int i = 0; i < N; i++) begin
            buf_block[BLK_WIDTH-1-i*W -: W]  = asm_q[i];
            beat_block[BLK_WIDTH-1-i*W -: W] = (count_q == CNT_W'(i)) ? tdata : asm_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        store_beat = 1'b0;
        load_beat  = 1'b0;
        load_buf   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (beat_acc) begin
                    if (!is_final) begin
                        store_beat = 1'b1;
                    end else if (out_free) begin
                        load_beat = 1'b1;
                    end else begin
                        store_beat = 1'b1;
                        state_d    = FULL;
                    end
                end
            end
            FULL: begin
                if (out_free) begin
                    load_buf = 1'b1;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= COLLECT;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= (state_d == COLLECT);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                asm_q[i] <= '0;
            end
            count_q     <= '0;
            pend_last_q <= 1'b0;
        end else if (load_beat || load_buf) begin
            for (int i = 0; i < N; i++) begin
                asm_q[i] <= '0;
            end
            count_q     <= '0;
            pend_last_q <= 1'b0;
        end else if (store_beat) begin
            asm_q[count_q] <= tdata;
            if (state_d == FULL) begin
                pend_last_q <= tlast;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Output register only reloads when free, which keeps data stable under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blk_tvalid_q <= 1'b0;
            blk_tlast_q  <= 1'b0;
            blk_tdata_q  <= '0;
        end else if (load_beat) begin
            blk_tvalid_q <= 1'b1;
            blk_tlast_q  <= tlast;
            blk_tdata_q  <= beat_block;
        end else if (load_buf) begin
            blk_tvalid_q <= 1'b1;
            blk_tlast_q  <= pend_last_q;
            blk_tdata_q  <= buf_block;
        end else if (blk_tvalid_q && blk_tready) begin
            blk_tvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_partial_q <= 1'b0;
        end else if (beat_acc && tlast && (count_q != LAST_IDX)) begin
            err_partial_q <= 1'b1;
        end
    end

    assign tready      = tready_q;
    assign blk_tvalid  = blk_tvalid_q;
    assign blk_tlast   = blk_tlast_q;
    assign blk_tdata   = blk_tdata_q;
    assign err_partial = err_partial_q;

endmodule
